// File: rtl/sr_readback_check.sv
// Read-back checker: latches the written configuration word, waits for the read-back word,
// then scans both serially one bit per cycle. Optional feature macro: SR_READBACK_MASK_EN (don't-care mask).
module sr_readback_check #(
  parameter int WIDTH     = 170,
  parameter int CNT_WIDTH = 8,
  parameter int TMO_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     expected,
`ifdef SR_READBACK_MASK_EN
  input  logic [WIDTH-1:0]     mask,
`endif
  input  logic                 valid,
  input  logic [WIDTH-1:0]     dout,
  input  logic [TMO_WIDTH-1:0] tmo_limit,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 timeout,
  output logic [CNT_WIDTH:0]   err_count,
  output logic [CNT_WIDTH-1:0] first_err
);

  typedef enum logic [1:0] {IDLE, WAIT, SCAN, DONE} state_t;

  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] IDX_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH:0]   ACC_ONE  = (CNT_WIDTH + 1)'(1);
  localparam logic [CNT_WIDTH:0]   ACC_MAX  = '1;
  localparam logic [TMO_WIDTH-1:0] TMO_ONE  = TMO_WIDTH'(1);

  state_t               state;
  logic [WIDTH-1:0]     exp_q;
  logic [WIDTH-1:0]     rd_q;
  logic [TMO_WIDTH-1:0] tmo_cnt;
  logic [CNT_WIDTH-1:0] idx;
  logic [CNT_WIDTH:0]   acc;
  logic                 found;
  logic [CNT_WIDTH-1:0] first_q;
`ifdef SR_READBACK_MASK_EN
  logic [WIDTH-1:0]     mask_q;
`endif

  logic                 bit_diff;
  logic [CNT_WIDTH:0]   acc_new;
  logic [CNT_WIDTH-1:0] first_new;

  // Mismatch evaluation for the bit currently under the scan index, folded into the running totals.
  always_comb begin
    bit_diff  = 1'b0;
    acc_new   = acc;
    first_new = first_q;
`ifdef SR_READBACK_MASK_EN
    bit_diff = (exp_q[idx] != rd_q[idx]) && !mask_q[idx];
`else
    bit_diff = (exp_q[idx] != rd_q[idx]);
`endif
    if (bit_diff) begin
      acc_new = (acc == ACC_MAX) ? acc : acc + ACC_ONE;
      if (!found)
        first_new = idx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      exp_q     <= '0;
      rd_q      <= '0;
      tmo_cnt   <= '0;
      idx       <= '0;
      acc       <= '0;
      found     <= 1'b0;
      first_q   <= '0;
`ifdef SR_READBACK_MASK_EN
      mask_q    <= '0;
`endif
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      timeout   <= 1'b0;
      err_count <= '0;
      first_err <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            exp_q   <= expected;
`ifdef SR_READBACK_MASK_EN
            mask_q  <= mask;
`endif
            tmo_cnt <= '0;
            idx     <= '0;
            acc     <= '0;
            found   <= 1'b0;
            first_q <= '0;
            busy    <= 1'b1;
            state   <= WAIT;
          end
        end
        WAIT: begin
          // A valid word takes priority over a timeout landing in the same cycle.
          if (valid) begin
            rd_q  <= dout;
            state <= SCAN;
          end else if (tmo_limit != '0) begin
            if (tmo_cnt == tmo_limit - TMO_ONE) begin
              pass      <= 1'b0;
              timeout   <= 1'b1;
              err_count <= '0;
              first_err <= '0;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              tmo_cnt <= tmo_cnt + TMO_ONE;
            end
          end
        end
        SCAN: begin
          acc     <= acc_new;
          first_q <= first_new;
          found   <= found | bit_diff;
          if (idx == LAST_IDX) begin
            pass      <= (acc_new == '0);
            timeout   <= 1'b0;
            err_count <= acc_new;
            first_err <= first_new;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + IDX_ONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
